// File: rtl/vga_reg_arbiter.sv
// Two-requester round-robin arbiter that turns single-word register requests into
// AXI4-Lite transactions towards the vga_control slave, one transaction at a time.
module vga_reg_arbiter #(
    parameter int unsigned C_ADDR_WIDTH = 4,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_NUM_REGS   = 4
) (
    input  logic                        ACLK,
    input  logic                        ARESET,

    input  logic [1:0]                  req_valid,
    input  logic [1:0]                  req_we,
    input  logic [2*C_ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*C_DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                  req_ack,
    output logic [1:0]                  req_done,
    output logic [C_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        busy,

    output logic [C_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                  M_AXI_AWPROT,
    output logic                        M_AXI_AWVALID,
    input  logic                        M_AXI_AWREADY,
    output logic [C_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                        M_AXI_WVALID,
    input  logic                        M_AXI_WREADY,
    input  logic [1:0]                  M_AXI_BRESP,
    input  logic                        M_AXI_BVALID,
    output logic                        M_AXI_BREADY,
    output logic [C_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                  M_AXI_ARPROT,
    output logic                        M_AXI_ARVALID,
    input  logic                        M_AXI_ARREADY,
    input  logic [C_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                  M_AXI_RRESP,
    input  logic                        M_AXI_RVALID,
    output logic                        M_AXI_RREADY
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWresp,
        StRd,
        StRresp,
        StDone
    } state_e;

    localparam logic [31:0] RegSpan = 32'(4 * C_NUM_REGS);

    state_e                    state_q, state_d;
    logic                      grant_q;
    logic                      last_grant_q;
    logic [C_ADDR_WIDTH-1:2]   cmd_addr_q;
    logic [C_DATA_WIDTH-1:0]   cmd_wdata_q;
    logic [1:0]                ack_q;
    logic                      aw_valid_q;
    logic                      w_valid_q;
    logic                      ar_valid_q;
    logic [C_DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]                resp_q;

    logic                      start;
    logic                      grant_sel;
    logic                      sel_we;
    logic                      sel_oor;
    logic [C_ADDR_WIDTH-1:0]   sel_addr;
    logic [C_DATA_WIDTH-1:0]   sel_wdata;
    logic                      aw_done;
    logic                      w_done;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_sel = 1'b0;
        case (req_valid)
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant_q;
            default: grant_sel = 1'b0;
        endcase
    end

    assign start     = (state_q == StIdle) && (req_valid != 2'b00);
    assign sel_we    = grant_sel ? req_we[1] : req_we[0];
    assign sel_addr  = grant_sel ? req_addr[2*C_ADDR_WIDTH-1:C_ADDR_WIDTH]
                                 : req_addr[C_ADDR_WIDTH-1:0];
    assign sel_wdata = grant_sel ? req_wdata[2*C_DATA_WIDTH-1:C_DATA_WIDTH]
                                 : req_wdata[C_DATA_WIDTH-1:0];
    assign sel_oor   = 32'(sel_addr) >= RegSpan;

    // A channel counts as finished once its valid has dropped or is handshaking now.
    assign aw_done = !aw_valid_q || M_AXI_AWREADY;
    assign w_done  = !w_valid_q || M_AXI_WREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (sel_oor) begin
                        state_d = StDone;
                    end else if (sel_we) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
                if (aw_done && w_done) begin
                    state_d = StWresp;
                end
            end
            StWresp: begin
                if (M_AXI_BVALID) begin
                    state_d = StDone;
                end
            end
            StRd: begin
                if (M_AXI_ARREADY) begin
                    state_d = StRresp;
                end
            end
            StRresp: begin
                if (M_AXI_RVALID) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            ack_q        <= 2'b00;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            ar_valid_q   <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= 2'b00;
        end else begin
            ack_q <= 2'b00;
            if (start) begin
                grant_q     <= grant_sel;
                cmd_addr_q  <= sel_addr[C_ADDR_WIDTH-1:2];
                cmd_wdata_q <= sel_wdata;
                ack_q       <= grant_sel ? 2'b10 : 2'b01;
                aw_valid_q  <= sel_we && !sel_oor;
                w_valid_q   <= sel_we && !sel_oor;
                ar_valid_q  <= !sel_we && !sel_oor;
                if (sel_oor) begin
                    rdata_q <= '0;
                    resp_q  <= 2'b11;
                end
            end
            if (aw_valid_q && M_AXI_AWREADY) begin
                aw_valid_q <= 1'b0;
            end
            if (w_valid_q && M_AXI_WREADY) begin
                w_valid_q <= 1'b0;
            end
            if (ar_valid_q && M_AXI_ARREADY) begin
                ar_valid_q <= 1'b0;
            end
            if ((state_q == StWresp) && M_AXI_BVALID) begin
                rdata_q <= '0;
                resp_q  <= M_AXI_BRESP;
            end
            if ((state_q == StRresp) && M_AXI_RVALID) begin
                rdata_q <= M_AXI_RDATA;
                resp_q  <= M_AXI_RRESP;
            end
            if (state_q == StDone) begin
                last_grant_q <= grant_q;
            end
        end
    end

    always_comb begin
        req_done = 2'b00;
        if (state_q == StDone) begin
            req_done = grant_q ? 2'b10 : 2'b01;
        end
    end

    assign req_ack       = ack_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign busy          = (state_q != StIdle);

    assign M_AXI_AWADDR  = {cmd_addr_q, 2'b00};
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = aw_valid_q;
    assign M_AXI_WDATA   = cmd_wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = w_valid_q;
    assign M_AXI_BREADY  = (state_q == StWresp);
    assign M_AXI_ARADDR  = {cmd_addr_q, 2'b00};
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = ar_valid_q;
    assign M_AXI_RREADY  = (state_q == StRresp);

endmodule

// File: tb/tb_vga_reg_arbiter.sv
// Directed bench for vga_reg_arbiter with a small AXI4-Lite register slave model and a
// scoreboard of expected completions.
module tb_vga_reg_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [2*AW-1:0]   req_addr;
    logic [2*DW-1:0]   req_wdata;
    logic [1:0]        req_ack;
    logic [1:0]        req_done;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              busy;
    logic [AW-1:0]     AWADDR;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY;
    logic [DW-1:0]     WDATA;
    logic [DW/8-1:0]   WSTRB;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [AW-1:0]     ARADDR;
    logic [2:0]        ARPROT;
    logic              ARVALID;
    logic              ARREADY;
    logic [DW-1:0]     RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    always #5 ACLK = ~ACLK;

    vga_reg_arbiter #(
        .C_ADDR_WIDTH (AW),
        .C_DATA_WIDTH (DW),
        .C_NUM_REGS   (NR)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ack       (req_ack),
        .req_done      (req_done),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .busy          (busy),
        .M_AXI_AWADDR  (AWADDR),
        .M_AXI_AWPROT  (AWPROT),
        .M_AXI_AWVALID (AWVALID),
        .M_AXI_AWREADY (AWREADY),
        .M_AXI_WDATA   (WDATA),
        .M_AXI_WSTRB   (WSTRB),
        .M_AXI_WVALID  (WVALID),
        .M_AXI_WREADY  (WREADY),
        .M_AXI_BRESP   (BRESP),
        .M_AXI_BVALID  (BVALID),
        .M_AXI_BREADY  (BREADY),
        .M_AXI_ARADDR  (ARADDR),
        .M_AXI_ARPROT  (ARPROT),
        .M_AXI_ARVALID (ARVALID),
        .M_AXI_ARREADY (ARREADY),
        .M_AXI_RDATA   (RDATA),
        .M_AXI_RRESP   (RRESP),
        .M_AXI_RVALID  (RVALID),
        .M_AXI_RREADY  (RREADY)
    );

    // ---------------- AXI4-Lite slave model ----------------
    logic [DW-1:0] sregs [NR];
    int unsigned   aw_delay = 0;
    int unsigned   aw_cnt;
    logic          b_stall = 1'b0;
    logic          aw_got, w_got, b_pend, r_pend;
    logic [AW-1:0] aw_addr_s;
    logic [DW-1:0] w_data_s, r_data_s;
    logic          aw_hs, w_hs, ar_hs;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
    assign WREADY  = WVALID;
    assign ARREADY = ARVALID;
    assign BVALID  = b_pend && !b_stall;
    assign BRESP   = 2'b00;
    assign RVALID  = r_pend;
    assign RDATA   = r_data_s;
    assign RRESP   = 2'b00;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign wr_addr = aw_hs ? AWADDR : aw_addr_s;
    assign wr_data = w_hs ? WDATA : w_data_s;

    always @(posedge ACLK) begin
        if (ARESET) begin
            aw_cnt <= 0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_pend <= 1'b0;
            r_pend <= 1'b0;
            for (int i = 0; i < NR; i++) sregs[i] <= '0;
        end else begin
            if (AWVALID && !AWREADY) aw_cnt <= aw_cnt + 1;
            else                     aw_cnt <= 0;
            if (aw_hs) aw_addr_s <= AWADDR;
            if (w_hs)  w_data_s  <= WDATA;
            if (BVALID && BREADY) b_pend <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs) && !b_pend) begin
                sregs[wr_addr[3:2]] <= wr_data;
                b_pend <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (aw_hs) aw_got <= 1'b1;
                if (w_hs)  w_got  <= 1'b1;
            end
            if (RVALID && RREADY) r_pend <= 1'b0;
            if (ar_hs) begin
                r_pend   <= 1'b1;
                r_data_s <= sregs[ARADDR[3:2]];
            end
        end
    end

    // ---------------- scoreboard and monitor state ----------------
    typedef struct {
        logic [1:0]    who;
        logic [DW-1:0] rdata;
        logic [1:0]    resp;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0;
    int            fails = 0;
    int            cyc;
    int            ack_cyc [2];
    int            done_cyc [2];
    int            aw_cyc, w_cyc, ar_cyc, b_hs, overlap;
    logic [AW-1:0] last_awaddr, last_araddr;
    logic [DW-1:0] last_wdata;
    logic [3:0]    last_wstrb;
    logic          prev_aw_pend = 1'b0, prev_w_pend = 1'b0, prev_ar_pend = 1'b0;
    logic [AW-1:0] prev_awaddr, prev_araddr;
    logic [DW-1:0] prev_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input int n, input logic [DW-1:0] d, input logic [1:0] r);
        exp_t e;
        e.who   = (n == 1) ? 2'b10 : 2'b01;
        e.rdata = d;
        e.resp  = r;
        sb.push_back(e);
    endfunction

    task automatic mark();
        cyc         = 0;
        ack_cyc     = '{-1, -1};
        done_cyc    = '{-1, -1};
        aw_cyc      = 0;
        w_cyc       = 0;
        ar_cyc      = 0;
        b_hs        = 0;
        last_awaddr = '0;
        last_araddr = '0;
        last_wdata  = '0;
        last_wstrb  = '0;
    endtask

    task automatic issue(input int n, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        req_valid[n]         = 1'b1;
        req_we[n]            = we;
        req_addr[n*AW +: AW] = a;
        req_wdata[n*DW +: DW] = d;
    endtask

    // One cycle: sample at the falling edge, act as the requesters, score completions.
    task automatic step();
        exp_t e;
        @(negedge ACLK);
        cyc++;
        for (int n = 0; n < 2; n++) begin
            if (req_ack[n]) begin
                ack_cyc[n]   = cyc;
                req_valid[n] = 1'b0;
            end
        end
        if (prev_aw_pend) check("awvalid_hold", 64'({AWVALID, AWADDR}), 64'({1'b1, prev_awaddr}));
        if (prev_w_pend)  check("wvalid_hold", 64'({WVALID, WDATA}), 64'({1'b1, prev_wdata}));
        if (prev_ar_pend) check("arvalid_hold", 64'({ARVALID, ARADDR}), 64'({1'b1, prev_araddr}));
        prev_aw_pend = AWVALID && !AWREADY;
        prev_w_pend  = WVALID && !WREADY;
        prev_ar_pend = ARVALID && !ARREADY;
        prev_awaddr  = AWADDR;
        prev_wdata   = WDATA;
        prev_araddr  = ARADDR;
        if (AWVALID) aw_cyc++;
        if (WVALID)  w_cyc++;
        if (ARVALID) ar_cyc++;
        if (BVALID && BREADY) b_hs++;
        if (aw_hs) begin
            last_awaddr = AWADDR;
            check("awprot", 64'(AWPROT), 64'd0);
        end
        if (w_hs) begin
            last_wdata = WDATA;
            last_wstrb = WSTRB;
        end
        if (ar_hs) begin
            last_araddr = ARADDR;
            check("arprot", 64'(ARPROT), 64'd0);
        end
        if ((AWVALID || WVALID || BREADY) && (ARVALID || RREADY)) overlap++;
        if (req_done != 2'b00) begin
            done_cyc[req_done[1] ? 1 : 0] = cyc;
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("done_who", 64'(req_done), 64'(e.who));
                check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            end
        end
    endtask

    task automatic wait_all(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) step();
        check("completion_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
        step();
    endtask

    task automatic do_reset();
        ARESET = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESET = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        overlap   = 0;
        mark();
        do_reset();

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ack_done", 64'({req_ack, req_done}), 64'd0);
        check("rst_rsp", 64'({rsp_rdata, rsp_resp}), 64'd0);
        check("rst_axi", 64'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 64'd0);

        // Single write, zero-wait slave
        mark();
        issue(0, 1'b1, 8'h04, 32'h0000_0002);
        push(0, 32'h0, 2'b00);
        wait_all(20);
        check("wr_ack_cyc", 64'(ack_cyc[0]), 64'd1);
        check("wr_done_cyc", 64'(done_cyc[0]), 64'd3);
        check("wr_awaddr", 64'(last_awaddr), 64'h4);
        check("wr_wdata", 64'(last_wdata), 64'h2);
        check("wr_wstrb", 64'(last_wstrb), 64'hf);

        // Host reads back a value the slave holds
        mark();
        issue(0, 1'b1, 8'h08, 32'h0000_0003);
        push(0, 32'h0, 2'b00);
        wait_all(20);
        mark();
        issue(1, 1'b0, 8'h08, 32'h0);
        push(1, 32'h0000_0003, 2'b00);
        wait_all(20);
        check("rd_ack_cyc", 64'(ack_cyc[1]), 64'd1);
        check("rd_done_cyc", 64'(done_cyc[1]), 64'd3);
        check("rd_araddr", 64'(last_araddr), 64'h8);

        // Unaligned address: low bits forced to zero on the bus
        mark();
        issue(0, 1'b0, 8'h06, 32'h0);
        push(0, 32'h0000_0002, 2'b00);
        wait_all(20);
        check("rd_unaligned_araddr", 64'(last_araddr), 64'h4);

        // Round robin after reset: 0, 1, then 0 alone, then a tie favours 1
        do_reset();
        overlap = 0;
        mark();
        issue(0, 1'b1, 8'h00, 32'h0000_0011);
        issue(1, 1'b1, 8'h04, 32'h0000_0022);
        push(0, 32'h0, 2'b00);
        push(1, 32'h0, 2'b00);
        wait_all(40);
        check("rr_first_done_cyc", 64'(done_cyc[0]), 64'd3);
        mark();
        issue(0, 1'b0, 8'h00, 32'h0);
        push(0, 32'h0000_0011, 2'b00);
        wait_all(20);
        mark();
        issue(0, 1'b0, 8'h04, 32'h0);
        issue(1, 1'b0, 8'h00, 32'h0);
        push(1, 32'h0000_0011, 2'b00);
        push(0, 32'h0000_0022, 2'b00);
        wait_all(40);
        check("rr_no_overlap", 64'(overlap), 64'd0);

        // Delayed AWREADY, immediate WREADY
        aw_delay = 3;
        mark();
        issue(1, 1'b1, 8'h0C, 32'hA5A5_0001);
        push(1, 32'h0, 2'b00);
        wait_all(30);
        aw_delay = 0;
        check("slow_aw_awvalid_cycles", 64'(aw_cyc), 64'd4);
        check("slow_aw_wvalid_cycles", 64'(w_cyc), 64'd1);
        check("slow_aw_b_count", 64'(b_hs), 64'd1);
        check("slow_aw_done_cyc", 64'(done_cyc[1]), 64'd6);
        mark();
        issue(0, 1'b0, 8'h0C, 32'h0);
        push(0, 32'hA5A5_0001, 2'b00);
        wait_all(20);

        // Reset while waiting for the write response
        b_stall = 1'b1;
        mark();
        issue(0, 1'b1, 8'h04, 32'h0000_0077);
        for (int i = 0; i < 20 && !BREADY; i++) step();
        check("abort_reached_wresp", 64'(BREADY), 64'd1);
        ARESET = 1'b1;
        step();
        b_stall = 1'b0;
        ARESET  = 1'b0;
        check("abort_ctrl_zero", 64'({busy, req_ack, req_done, AWVALID, WVALID, BREADY,
                                      ARVALID, RREADY}), 64'd0);
        check("abort_rsp_zero", 64'({rsp_rdata, rsp_resp}), 64'd0);
        repeat (3) step();
        check("abort_no_done", 64'(done_cyc[0]), 64'(-1));
        mark();
        issue(1, 1'b1, 8'h00, 32'h0000_1234);
        push(1, 32'h0, 2'b00);
        wait_all(20);
        check("post_abort_ack_cyc", 64'(ack_cyc[1]), 64'd1);
        check("post_abort_done_cyc", 64'(done_cyc[1]), 64'd3);
        mark();
        issue(0, 1'b0, 8'h00, 32'h0);
        push(0, 32'h0000_1234, 2'b00);
        wait_all(20);

        // Out-of-range read and write: DECERR, no bus traffic
        mark();
        issue(0, 1'b0, 8'h10, 32'h0);
        push(0, 32'h0, 2'b11);
        wait_all(10);
        check("oor_rd_ack_cyc", 64'(ack_cyc[0]), 64'd1);
        check("oor_rd_done_cyc", 64'(done_cyc[0]), 64'd1);
        check("oor_rd_no_ar", 64'(ar_cyc), 64'd0);
        mark();
        issue(1, 1'b1, 8'hFF, 32'hDEAD_BEEF);
        push(1, 32'h0, 2'b11);
        wait_all(10);
        check("oor_wr_no_aw", 64'(aw_cyc + w_cyc), 64'd0);
        check("oor_wr_done_cyc", 64'(done_cyc[1]), 64'd1);

        // Last in-range register still decodes
        mark();
        issue(1, 1'b0, 8'h0F, 32'h0);
        push(1, 32'h0, 2'b00);
        wait_all(20);
        check("edge_reg_araddr", 64'(last_araddr), 64'hC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
